// File: rtl/lane_fifo_pair.sv
// lane_fifo_pair: two independent per-lane FIFOs behind the 2-way lane demux.
// Each lane buffers pushed words, returns them on pop with one cycle of
// latency, reports occupancy flags and keeps sticky overflow/underflow flags.

// One lane: circular buffer with registered read port.
module lane_fifo_lane #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              err_ovf,
    output logic              err_udf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              pop_ok, push_ok;

    // A pop frees a slot in the same cycle, so a full lane can still take a push.
    assign pop_ok       = pop && (count != '0);
    assign push_ok      = valid_in && (!full || pop_ok);
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

    // Pointers, occupancy, read port and sticky error flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (valid_in && !push_ok)   err_ovf <= 1'b1;
            if (pop && (count == '0))   err_udf <= 1'b1;
        end
    end
endmodule

// Top: two lane instances plus the shared back-pressure output.
module lane_fifo_pair #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    output logic              full_0,
    output logic              full_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              almost_empty_0,
    output logic              almost_empty_1,
    output logic              pause,
    output logic [1:0]        err_overflow,
    output logic [1:0]        err_underflow
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;
    logic [NUM_LANES-1:0] vin, pop, vout, full, empty, afull, aempty;

    assign din  = {data_in1, data_in0};
    assign vin  = {valid_in1, valid_in0};
    assign pop  = {pop_1, pop_0};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_fifo_lane #(
            .DATA_W(DATA_W), .DEPTH(DEPTH),
            .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
        ) u_lane (
            .clk(clk), .reset_L(reset_L),
            .data_in(din[l]), .valid_in(vin[l]), .pop(pop[l]),
            .data_out(dout[l]), .valid_out(vout[l]),
            .full(full[l]), .empty(empty[l]),
            .almost_full(afull[l]), .almost_empty(aempty[l]),
            .err_ovf(err_overflow[l]), .err_udf(err_underflow[l])
        );
    end

    assign data_out0      = dout[0];
    assign data_out1      = dout[1];
    assign valid_out0     = vout[0];
    assign valid_out1     = vout[1];
    assign full_0         = full[0];
    assign full_1         = full[1];
    assign empty_0        = empty[0];
    assign empty_1        = empty[1];
    assign almost_full_0  = afull[0];
    assign almost_full_1  = afull[1];
    assign almost_empty_0 = aempty[0];
    assign almost_empty_1 = aempty[1];
    // Either lane nearing capacity stalls the shared upstream source.
    assign pause          = |afull;
endmodule

// File: tb/tb_lane_fifo_pair.sv
// Testbench for lane_fifo_pair: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the two lanes.
module tb_lane_fifo_pair;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [5:0] data_in0 = '0, data_in1 = '0;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, pop_0 = 1'b0, pop_1 = 1'b0;
    logic [5:0] data_out0, data_out1;
    logic       valid_out0, valid_out1, full_0, full_1, empty_0, empty_1;
    logic       almost_full_0, almost_full_1, almost_empty_0, almost_empty_1, pause;
    logic [1:0] err_overflow, err_underflow;

    always #5 clk = ~clk;

    lane_fifo_pair dut (
        .clk(clk), .reset_L(reset_L),
        .data_in0(data_in0), .valid_in0(valid_in0),
        .data_in1(data_in1), .valid_in1(valid_in1),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out0(data_out0), .valid_out0(valid_out0),
        .data_out1(data_out1), .valid_out1(valid_out1),
        .full_0(full_0), .full_1(full_1),
        .empty_0(empty_0), .empty_1(empty_1),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .almost_empty_0(almost_empty_0), .almost_empty_1(almost_empty_1),
        .pause(pause), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per lane plus expected read port and errors.
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [1:0][5:0] exp_dout;
    logic [1:0] exp_vout, exp_ovf, exp_udf;

    function automatic int qsize(int l);
        return (l == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        exp_dout = '0;
        exp_vout = '0;
        exp_ovf  = '0;
        exp_udf  = '0;
    endtask

    task automatic model_lane(int l, bit v, logic [5:0] d, bit p);
        int sz;
        bit pok, wok;
        sz  = qsize(l);
        pok = p && (sz != 0);
        wok = v && ((sz < DEPTH) || pok);
        exp_vout[l] = pok;
        if (pok) exp_dout[l] = (l == 0) ? q0.pop_front() : q1.pop_front();
        if (wok) begin
            if (l == 0) q0.push_back(d);
            else        q1.push_back(d);
        end
        if (v && !wok)     exp_ovf[l] = 1'b1;
        if (p && (sz == 0)) exp_udf[l] = 1'b1;
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int s0, s1;
        s0 = q0.size();
        s1 = q1.size();
        chk({tag, " lane0 data"}, 16'(data_out0), 16'(exp_dout[0]));
        chk({tag, " lane0 vld/full/empty/af/ae"},
            16'({valid_out0, full_0, empty_0, almost_full_0, almost_empty_0}),
            16'({exp_vout[0], s0 == DEPTH, s0 == 0, s0 >= 3, s0 <= 1}));
        chk({tag, " lane1 data"}, 16'(data_out1), 16'(exp_dout[1]));
        chk({tag, " lane1 vld/full/empty/af/ae"},
            16'({valid_out1, full_1, empty_1, almost_full_1, almost_empty_1}),
            16'({exp_vout[1], s1 == DEPTH, s1 == 0, s1 >= 3, s1 <= 1}));
        chk({tag, " pause/ovf/udf"},
            16'({pause, err_overflow, err_underflow}),
            16'({(s0 >= 3) || (s1 >= 3), exp_ovf, exp_udf}));
    endtask

    // Apply one cycle of inputs from the falling edge, check after the next one.
    task automatic step(bit v0, logic [5:0] d0, bit v1, logic [5:0] d1,
                        bit p0, bit p1, string tag);
        valid_in0 = v0; data_in0 = d0;
        valid_in1 = v1; data_in1 = d1;
        pop_0 = p0; pop_1 = p1;
        model_lane(0, v0, d0, p0);
        model_lane(1, v1, d1, p1);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int thresh_push, thresh_pop;
        // Reset held low: everything cleared, empty/almost_empty set.
        model_reset();
        #3;
        check_all("reset hold");
        @(negedge clk);
        reset_L = 1'b1;

        // Lane 0 fill then drain in order.
        for (int i = 1; i <= 4; i++) step(1, 6'(i), 0, 0, 0, 0, "fill0");
        for (int i = 0; i < 4; i++)  step(0, 0, 0, 0, 1, 0, "drain0");
        step(0, 0, 0, 0, 0, 0, "idle0");

        // Lane 1 overflow: fifth push dropped.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 6'h21 + 6'(i), 0, 0, "fill1");
        step(0, 0, 1, 6'h25, 0, 0, "overflow1");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, "drain1");

        // Full lane 0 with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1, 6'h11 + 6'(i), 0, 0, 0, 0, "refill0");
        step(1, 6'h0A, 0, 0, 1, 0, "full push+pop");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, "drain after full");

        // Empty lane 1 with simultaneous push and pop: no fall-through.
        step(0, 0, 1, 6'h30, 0, 1, "empty push+pop");
        step(0, 0, 0, 0, 0, 1, "pop after empty");

        // Asynchronous reset mid-cycle with two words stored per lane.
        step(1, 6'h05, 1, 6'h26, 0, 0, "pre-reset a");
        step(1, 6'h06, 1, 6'h27, 0, 0, "pre-reset b");
        valid_in0 = 0; valid_in1 = 0; pop_0 = 0; pop_1 = 0;
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        @(negedge clk);
        reset_L = 1'b1;
        check_all("after reset");

        // Random interleaved traffic with phases biased toward fill and drain.
        for (int blk = 0; blk < 12; blk++) begin
            thresh_push = (blk % 2 == 0) ? 75 : 35;
            thresh_pop  = (blk % 2 == 0) ? 35 : 75;
            for (int c = 0; c < 25; c++) begin
                step($urandom_range(0, 99) < thresh_push, 6'($urandom_range(0, 63)),
                     $urandom_range(0, 99) < thresh_push, 6'($urandom_range(0, 63)),
                     $urandom_range(0, 99) < thresh_pop,
                     $urandom_range(0, 99) < thresh_pop, "random");
            end
        end
        step(0, 0, 0, 0, 0, 0, "final idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lane_fifo_pair.md
Name: lane_fifo_pair

Overview:
- Dual-lane buffering stage directly downstream of the 6-bit two-way lane demux.
- Captures each lane's registered data/valid pair into an independent FIFO and releases words on per-lane pop requests.
- Exposes occupancy flags, a combined back-pressure signal toward the demux's source, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 6, word width; matches the demux lane width, bit 5 is the lane tag.
- DEPTH, 4, entries per lane; must be a power of two, >=2.
- AF_THRESH, 3, almost-full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost-empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_L  in  1  asynchronous active-low reset
- data_in0  in  DATA_W  lane 0 word from demux dataout0
- valid_in0  in  1  lane 0 push qualifier (demux valid_0)
- data_in1  in  DATA_W  lane 1 word from demux dataout1
- valid_in1  in  1  lane 1 push qualifier (demux valid_1)
- pop_0  in  1  lane 0 read request
- pop_1  in  1  lane 1 read request
- data_out0  out  DATA_W  lane 0 registered read data
- valid_out0  out  1  data_out0 valid, one-cycle pulse per accepted pop
- data_out1  out  DATA_W  lane 1 registered read data
- valid_out1  out  1  data_out1 valid
- full_0, full_1  out  1 each  count == DEPTH
- empty_0, empty_1  out  1 each  count == 0
- almost_full_0, almost_full_1  out  1 each  count >= AF_THRESH
- almost_empty_0, almost_empty_1  out  1 each  count <= AE_THRESH
- pause  out  1  almost_full_0 OR almost_full_1; back-pressure to the upstream source
- err_overflow  out  2  bit i sticky, lane i push dropped
- err_underflow  out  2  bit i sticky, lane i pop on empty

Behaviour:
- Reset (asynchronous, reset_L low): pointers and counts go to 0 immediately.
  - data_out0/1 = 0, valid_out0/1 = 0, err_overflow = 0, err_underflow = 0.
  - Flags derived from reset counts: empty = 1, almost_empty = 1, full = 0, almost_full = 0, pause = 0.
  - Reset mid-operation discards all stored words. Storage array contents are not reset.
- Lanes are fully independent. The per-lane rules below apply identically to lane 0 and lane 1.
- State per lane:
  - wr_ptr and rd_ptr, log2(DEPTH) bits, wrap modulo DEPTH.
  - count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Push acceptance:
  - Accepted when valid_in is high and (not full, or a pop is accepted in the same cycle).
  - An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop acceptance:
  - Accepted when pop is high and count != 0.
  - An accepted pop registers mem[rd_ptr] onto data_out and sets valid_out = 1 in the next cycle (latency 1).
  - rd_ptr increments.
  - Cycles without an accepted pop: valid_out = 0; data_out holds its last value.
- count update:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both accepted, count stays DEPTH, full stays 1.
  - When empty: push accepted, pop rejected (no fall-through). Sets err_underflow bit; count becomes 1.
- Overflow: valid_in with full and no accepted pop drops the word. err_overflow bit sets and stays 1 until reset; count and pointers unchanged.
- Underflow: pop with count == 0 is ignored. err_underflow bit sets (sticky); valid_out stays 0.
- All flags and pause are combinational from the current registered count; no extra delay.
- Data ordering: strict FIFO per lane. Data bits, including bit 5, pass unmodified.

Test Plan:
- Reset: hold reset_L = 0 → all outputs 0 except empty_0/1 = 1 and almost_empty_0/1 = 1. Then pulse reset_L low asynchronously mid-cycle with 2 words stored → count = 0 before the next edge.
- Lane 0 fill: push 0x01, 0x02, 0x03, 0x04 on valid_in0 → almost_full_0 and pause = 1 after the 3rd edge; full_0 = 1 after the 4th. Pop 4 times → data_out0 = 0x01..0x04 with valid_out0 one cycle after each pop; then empty_0 = 1.
- Overflow: lane 1 full (0x21..0x24), push 0x25 without a pop → err_overflow = 2'b10. Drain → reads 0x21..0x24 only.
- Full simultaneous push/pop: lane 0 full, push 0x0A and pop_0 in the same cycle → data_out0 = oldest word, count stays 4. The fourth subsequent read returns 0x0A.
- Underflow and empty simultaneous push/pop: empty lane 1, pop_1 and push 0x30 together → valid_out1 = 0, err_underflow = 2'b10. Next cycle pop → data_out1 = 0x30.
- Independent lanes with pointer wrap: random interleaved pushes/pops on both lanes for more than 3×DEPTH words → each lane preserves order across wrap. Flags match a scoreboard count every cycle.
